gf_stage_sequencer: RTL and testbench

Top-level scheduler for the guided-filter pipeline. It runs up to NUM_STAGES compute stages one after another, for example the mean, variance, calcu_a and calcu_b passes over the 300x210 frame. Each stage uses the existing ena/done handshake: a one-cycle ena pulse launches a stage, and the stage returns a one-cycle done pulse. The block also drives the select index used by the shared-RAM port mux, and a watchdog catches stages that never complete.

---
 rtl/gf_seq_pkg.sv | 25 ++
 rtl/gf_next_stage.sv | 28 ++
 rtl/gf_stage_sequencer.sv | 142 ++++++++++++++
 tb/tb_gf_stage_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf_seq_pkg.sv
// Shared types and constants for the guided-filter stage sequencer.
// Stage indices name the filter passes in the order they normally run.
package gf_seq_pkg;

   localparam int NUM_STAGES_DEF = 6;
   localparam int IDX_W_DEF      = 3;
   localparam int TIMEOUT_DEF    = 70000;
   localparam int TO_W_DEF       = 17;

   localparam int STG_MEAN_I = 0;
   localparam int STG_MEAN_P = 1;
   localparam int STG_CORR   = 2;
   localparam int STG_VAR    = 3;
   localparam int STG_A      = 4;
   localparam int STG_B      = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_NEXT,
      ST_FINISH
   } seq_state_e;

endpackage

// File: rtl/gf_next_stage.sv
// Finds the next enabled stage: lowest set mask bit strictly above i_idx,
// or the lowest set bit overall when i_first is high.
module gf_next_stage
   import gf_seq_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int IDX_W      = IDX_W_DEF
) (
   input  logic [NUM_STAGES-1:0] i_mask,
   input  logic [IDX_W-1:0]      i_idx,
   input  logic                  i_first,
   output logic [IDX_W-1:0]      o_idx,
   output logic                  o_found
);

   // Scan from the top down so the last hit is the lowest qualifying bit.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (i_mask[i] && (i_first || (i > int'(i_idx)))) begin
            o_idx   = IDX_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gf_stage_sequencer.sv
// Runs the enabled guided-filter stages in index order over the ena/done
// handshake, drives the shared-RAM select and watches for hung stages.
module gf_stage_sequencer
   import gf_seq_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int TO_W       = TO_W_DEF
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_STAGES-1:0] stage_mask,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_ena,
   output logic [IDX_W-1:0]      sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [IDX_W-1:0]      err_stage
);

   seq_state_e            r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [NUM_STAGES-1:0] r_mask;
   logic [TO_W-1:0]       r_timer;
   logic                  r_err;
   logic [IDX_W-1:0]      r_err_stage;
   logic [NUM_STAGES-1:0] r_ena;
   logic                  r_done;
   logic                  r_busy;

   logic                  w_first;
   logic [NUM_STAGES-1:0] w_scan_mask;
   logic [IDX_W-1:0]      w_nxt_idx;
   logic                  w_found;
   logic [NUM_STAGES-1:0] w_nxt_onehot;
   logic                  w_cur_done;
   logic                  w_timeout;

   // In IDLE the search looks at the incoming mask; afterwards at the latched one.
   assign w_first      = (r_state == ST_IDLE);
   assign w_scan_mask  = w_first ? stage_mask : r_mask;
   assign w_nxt_onehot = NUM_STAGES'(1) << w_nxt_idx;
   assign w_cur_done   = stage_done[r_idx];
   assign w_timeout    = (r_timer == TO_W'(TIMEOUT - 1));

   gf_next_stage #(
      .NUM_STAGES (NUM_STAGES),
      .IDX_W      (IDX_W)
   ) u_next (
      .i_mask  (w_scan_mask),
      .i_idx   (r_idx),
      .i_first (w_first),
      .o_idx   (w_nxt_idx),
      .o_found (w_found)
   );

   // Pulse outputs are registered alongside the state transition that implies them.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_mask      <= '0;
         r_timer     <= '0;
         r_err       <= 1'b0;
         r_err_stage <= '0;
         r_ena       <= '0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_ena  <= '0;
         r_done <= 1'b0;
         if (abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_mask      <= stage_mask;
                     r_err       <= 1'b0;
                     r_err_stage <= '0;
                     r_busy      <= 1'b1;
                     if (w_found) begin
                        r_idx   <= w_nxt_idx;
                        r_ena   <= w_nxt_onehot;
                        r_state <= ST_LAUNCH;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                     end
                  end
               end
               ST_LAUNCH: begin
                  r_timer <= '0;
                  r_state <= ST_WAIT;
               end
               ST_WAIT: begin
                  r_timer <= r_timer + 1'b1;
                  if (w_cur_done) begin
                     r_state <= ST_NEXT;
                  end else if (w_timeout) begin
                     r_err       <= 1'b1;
                     r_err_stage <= r_idx;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
               ST_NEXT: begin
                  if (w_found) begin
                     r_idx   <= w_nxt_idx;
                     r_ena   <= w_nxt_onehot;
                     r_state <= ST_LAUNCH;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= ST_FINISH;
                  end
               end
               ST_FINISH: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign stage_ena = r_ena;
   assign sel       = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign err_stage = r_err_stage;

endmodule

// File: tb/tb_gf_stage_sequencer.sv
// Randomized bench: each sequence's expected output trace is derived from the
// handshake latency rules and compared cycle by cycle against the sequencer.
module tb_gf_stage_sequencer;
   import gf_seq_pkg::*;

   localparam int NS    = 6;
   localparam int IW    = 3;
   localparam int TO    = 20;
   localparam int LEN   = 256;
   localparam int NEVER = 99;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NS-1:0] stage_mask = '0;
   logic [NS-1:0] stage_done = '0;
   logic [NS-1:0] stage_ena;
   logic [IW-1:0] sel;
   logic          busy;
   logic          done;
   logic          err;
   logic [IW-1:0] err_stage;

   gf_stage_sequencer #(
      .NUM_STAGES (NS),
      .IDX_W      (IW),
      .TIMEOUT    (TO),
      .TO_W       (17)
   ) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .start      (start),
      .abort      (abort),
      .stage_mask (stage_mask),
      .stage_done (stage_done),
      .stage_ena  (stage_ena),
      .sel        (sel),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_stage  (err_stage)
   );

   always #5 iCLK = ~iCLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected trace for one sequence, cycle 0 = cycle in which start is applied.
   bit            e_busy [LEN];
   bit            e_done [LEN];
   logic [NS-1:0] e_ena  [LEN];
   logic [IW-1:0] e_sel  [LEN];
   bit            e_err  [LEN];
   logic [IW-1:0] e_es   [LEN];
   int            resp   [LEN];
   int            lat    [NS];
   int            seq_len;
   int            seq_no = 0;
   logic [IW-1:0] p_sel = '0;
   bit            p_err = 1'b0;
   logic [IW-1:0] p_es  = '0;

   task automatic build(input logic [NS-1:0] mask, input int abort_cyc);
      int  t = 1;
      int  last_end = 0;
      int  s_last = -1;
      bit  timed_out = 1'b0;
      for (int i = 0; i < LEN; i++) begin
         e_busy[i] = 1'b0;
         e_done[i] = 1'b0;
         e_ena[i]  = '0;
         e_sel[i]  = p_sel;
         e_err[i]  = (i == 0) ? p_err : 1'b0;
         e_es[i]   = (i == 0) ? p_es : '0;
         resp[i]   = -1;
      end
      for (int s = 0; s < NS; s++) begin
         if (mask[s] && !timed_out) begin
            e_ena[t] = NS'(1) << s;
            s_last   = s;
            if (lat[s] <= TO) begin
               resp[t + lat[s]] = s;
               for (int u = t; u <= t + lat[s] + 1; u++) begin
                  e_busy[u] = 1'b1;
                  e_sel[u]  = IW'(s);
               end
               t = t + lat[s] + 2;
            end else begin
               for (int u = t; u <= t + TO; u++) begin
                  e_busy[u] = 1'b1;
                  e_sel[u]  = IW'(s);
               end
               last_end  = t + TO;
               timed_out = 1'b1;
            end
         end
      end
      if (!timed_out) begin
         e_busy[t] = 1'b1;
         e_done[t] = 1'b1;
         if (s_last >= 0) e_sel[t] = IW'(s_last);
         last_end = t;
      end
      for (int u = last_end + 1; u < LEN; u++) begin
         e_sel[u] = e_sel[last_end];
         if (timed_out) begin
            e_err[u] = 1'b1;
            e_es[u]  = IW'(s_last);
         end
      end
      // Abort freezes everything after its cycle; outputs of that cycle still stand.
      if (abort_cyc > 0 && abort_cyc <= last_end) begin
         for (int u = abort_cyc + 1; u < LEN; u++) begin
            e_busy[u] = 1'b0;
            e_done[u] = 1'b0;
            e_ena[u]  = '0;
            e_sel[u]  = e_sel[abort_cyc];
            e_err[u]  = e_err[abort_cyc];
            e_es[u]   = e_es[abort_cyc];
            resp[u]   = -1;
         end
         last_end = abort_cyc;
      end
      seq_len = last_end + 3;
   endtask

   task automatic run(input logic [NS-1:0] mask, input int abort_cyc, input bit noise);
      logic [NS-1:0] dn;
      logic [NS-1:0] nz;
      build(mask, abort_cyc);
      for (int t = 0; t < seq_len; t++) begin
         start      = (t == 0) || (e_busy[t] && $urandom_range(7) == 0);
         abort      = (abort_cyc != 0 && t == abort_cyc) ||
                      ((t == 0 || !e_busy[t]) && $urandom_range(3) == 0);
         stage_mask = (t == 0) ? mask : NS'($urandom);
         dn = '0;
         if (resp[t] >= 0) dn[resp[t]] = 1'b1;
         if (noise) begin
            nz = NS'($urandom) & NS'($urandom);
            if (e_busy[t]) nz[e_sel[t]] = 1'b0;
            dn = dn | nz;
         end
         stage_done = dn;
         @(negedge iCLK);
         chk($sformatf("seq%0d_c%0d", seq_no, t),
             {17'd0, busy, done, stage_ena, sel, err, err_stage},
             {17'd0, e_busy[t], e_done[t], e_ena[t], e_sel[t], e_err[t], e_es[t]});
         @(posedge iCLK);
         #1;
      end
      start      = 1'b0;
      abort      = 1'b0;
      stage_done = '0;
      p_sel = e_sel[seq_len - 1];
      p_err = e_err[seq_len - 1];
      p_es  = e_es[seq_len - 1];
      seq_no++;
   endtask

   task automatic rand_lat(input bit allow_hang);
      for (int s = 0; s < NS; s++)
         lat[s] = (allow_hang && $urandom_range(9) == 0) ? NEVER : int'($urandom_range(12, 1));
   endtask

   initial begin
      repeat (2) @(posedge iCLK);
      #1;
      chk("reset", {17'd0, busy, done, stage_ena, sel, err, err_stage}, 32'd0);
      iRST = 1'b0;
      @(posedge iCLK);
      #1;

      // Full run, every stage answers 10 cycles after its launch.
      for (int s = 0; s < NS; s++) lat[s] = 10;
      run(6'b111111, 0, 1'b0);
      // Sparse mask.
      rand_lat(1'b0);
      run(6'b101001, 0, 1'b1);
      // Empty mask.
      run(6'b000000, 0, 1'b0);
      // Stage 2 hangs; the following run must clear err.
      for (int s = 0; s < NS; s++) lat[s] = 5;
      lat[STG_CORR] = NEVER;
      run(6'b111111, 0, 1'b0);
      rand_lat(1'b0);
      run(6'b000110, 0, 1'b0);
      // Spurious done on other stages, then abort together with stage 1 done (cycle 15).
      for (int s = 0; s < NS; s++) lat[s] = 6;
      run(6'b111111, 15, 1'b1);
      // Abort exactly on the timeout cycle: abort wins, no err.
      for (int s = 0; s < NS; s++) lat[s] = NEVER;
      run(6'b000001, 1 + TO, 1'b0);

      for (int k = 0; k < 40; k++) begin
         rand_lat(1'b1);
         run(NS'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(60, 1)) : 0,
             1'b1);
      end

      // Asynchronous reset while stage 4 is waiting.
      start      = 1'b1;
      stage_mask = 6'b110000;
      stage_done = '0;
      @(posedge iCLK);
      #1;
      start = 1'b0;
      repeat (4) @(posedge iCLK);
      @(negedge iCLK);
      chk("pre_rst_wait", {28'd0, busy, sel}, {28'd0, 1'b1, 3'd4});
      #2 iRST = 1'b1;
      #1;
      chk("async_rst", {17'd0, busy, done, stage_ena, sel, err, err_stage}, 32'd0);
      #1 iRST = 1'b0;
      @(posedge iCLK);
      #1;
      @(negedge iCLK);
      chk("post_rst", {17'd0, busy, done, stage_ena, sel, err, err_stage}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
